// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bus between the EX stage and the multiply sequencer.
interface muldiv_sequencer_if;
    localparam int unsigned W = 32;

    logic         start;
    logic         is_signed;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         rd_hi;
    logic         rd_lo;
    logic         flush;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] rd_data;

    modport master (
        output start, is_signed, op_a, op_b, rd_hi, rd_lo, flush,
        input  busy, stall, done, hi, lo, rd_data
    );

    modport slave (
        input  start, is_signed, op_a, op_b, rd_hi, rd_lo, flush,
        output busy, stall, done, hi, lo, rd_data
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Radix-2 shift-add multiply sequencer with architectural HI/LO for the EX stage.
// Define MULDIV_SIGNED_EN to honour is_signed (mult); otherwise every multiply is multu.
module muldiv_sequencer (
    input  logic               clk,
    input  logic               rst,
    muldiv_sequencer_if.slave  bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned PW = 64;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_count;
    logic [W-1:0]   r_mcand;
    logic [W-1:0]   r_mplier;
    logic [PW-1:0]  r_acc;
    logic           r_neg;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic           r_done;

    logic           w_busy;
    logic           w_accept;
    logic           w_last;
    logic [W:0]     w_sum;
    logic [PW-1:0]  w_prod;
    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic           w_neg;

    // Operand sign handling: magnitudes go to the unsigned core, sign restored in FIX.
`ifdef MULDIV_SIGNED_EN
    always_comb begin
        w_mag_a = (bus.is_signed && bus.op_a[W-1]) ? W'(-bus.op_a) : bus.op_a;
        w_mag_b = (bus.is_signed && bus.op_b[W-1]) ? W'(-bus.op_b) : bus.op_b;
        w_neg   = bus.is_signed & (bus.op_a[W-1] ^ bus.op_b[W-1]);
    end
`else
    logic w_unused_signed;
    assign w_unused_signed = bus.is_signed;
    always_comb begin
        w_mag_a = bus.op_a;
        w_mag_b = bus.op_b;
        w_neg   = 1'b0;
    end
`endif

    assign w_busy   = (r_state != S_IDLE);
    assign w_accept = (r_state == S_IDLE) & bus.start & ~bus.flush;
    assign w_last   = (r_count == CW'(W - 1));
    assign w_sum    = (W+1)'(r_acc[PW-1:W]) + (r_mplier[0] ? (W+1)'(r_mcand) : (W+1)'(0));
    assign w_prod   = r_neg ? PW'(-r_acc) : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_RUN;
            S_RUN: begin
                if (bus.flush)   w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_FIX;
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, one shift-add step per RUN cycle, commit in FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_neg    <= w_neg;
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                S_RUN: begin
                    if (!bus.flush) begin
                        r_acc    <= {w_sum, r_acc[W-1:1]};
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + CW'(1);
                    end
                end
                S_FIX: begin
                    if (!bus.flush) begin
                        r_hi   <= w_prod[PW-1:W];
                        r_lo   <= w_prod[W-1:0];
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = w_busy;
    assign bus.stall   = w_busy & (bus.start | bus.rd_hi | bus.rd_lo);
    assign bus.done    = r_done;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.rd_data = bus.rd_hi ? r_hi : r_lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed scoreboard bench for muldiv_sequencer: latency, stalls, flush and HI/LO results.
module tb_muldiv_sequencer;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_push = 0;
    int   n_done = 0;
    int   cyc;
    logic [63:0] sb[$];

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        if (s && SIGNED_EN) begin
            sa  = {{32{a[31]}}, a};
            sbv = {{32{b[31]}}, b};
            return 64'(sa * sbv);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Result checker: every done pulse must match the oldest outstanding multiply.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("done_unexpected", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("hi", 64'(bus.hi), 64'(e[63:32]));
                chk("lo", 64'(bus.lo), 64'(e[31:0]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
        bus.start     = 1'b1;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.is_signed = s;
        if (push) begin
            sb.push_back(model(a, b, s));
            n_push++;
        end
    endtask

    // Steps from the accept cycle to the done cycle; cyc counts cycles after the accept edge.
    task automatic step_until_done(input int rd_at, input int stall_from, input bit hold,
                                   input logic [31:0] na, input logic [31:0] nb, output int c);
        bit seen;
        seen = 1'b0;
        c    = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            c++;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (c == 1) chk("busy_run", 64'(bus.busy), 64'd1);
            if (c >= stall_from) chk("stall_held", 64'(bus.stall), 64'd1);
            if (c == 1) begin
                if (hold) begin
                    bus.op_a      = na;
                    bus.op_b      = nb;
                    bus.is_signed = 1'b0;
                end else begin
                    bus.start = 1'b0;
                end
            end
            if (c == rd_at) bus.rd_lo = 1'b1;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic finish_op(input string tag, input int c);
        chk(tag, 64'(c), 64'd34);
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(bus.done), 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.op_a      = 32'hFFFF_FFFF;
        bus.op_b      = 32'hFFFF_FFFF;
        bus.rd_hi     = 1'b0;
        bus.rd_lo     = 1'b0;
        bus.flush     = 1'b0;

        // Reset held two cycles with start asserted.
        repeat (2) @(negedge clk);
        chk("rst_hi",    64'(bus.hi),    64'd0);
        chk("rst_lo",    64'(bus.lo),    64'd0);
        chk("rst_busy",  64'(bus.busy),  64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        chk("rst_done",  64'(bus.done),  64'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("no_start_after_rst", 64'(bus.busy), 64'd0);

        // Unsigned all-ones product.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step_until_done(-1, 1000, 1'b0, 32'd0, 32'd0, cyc);
        finish_op("lat_ones", cyc);

        // Signed cases (unsigned results when signed support is compiled out).
        issue(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
        step_until_done(-1, 1000, 1'b0, 32'd0, 32'd0, cyc);
        finish_op("lat_m3x5", cyc);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        step_until_done(-1, 1000, 1'b0, 32'd0, 32'd0, cyc);
        finish_op("lat_minsq", cyc);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
        step_until_done(-1, 1000, 1'b0, 32'd0, 32'd0, cyc);
        finish_op("lat_7xm2", cyc);
        issue(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1);
        step_until_done(-1, 1000, 1'b0, 32'd0, 32'd0, cyc);
        finish_op("lat_m5x0", cyc);

        // mflo issued 10 cycles into 7 x 6 stalls until the done cycle.
        issue(32'd7, 32'd6, 1'b0, 1'b1);
        step_until_done(10, 11, 1'b0, 32'd0, 32'd0, cyc);
        chk("mflo_stall_release", 64'(bus.stall), 64'd0);
        chk("mflo_rd_data", 64'(bus.rd_data), 64'h2A);
        bus.rd_lo = 1'b0;
        bus.rd_hi = 1'b1;
        #1;
        chk("mfhi_rd_data", 64'(bus.rd_data), 64'd0);
        bus.rd_hi = 1'b0;
        finish_op("lat_7x6", cyc);

        // Establish HI/LO = 0x11111111/0x22222222, then flush a multiply midway.
        issue(32'h2222_2222, 32'h8000_0001, 1'b0, 1'b1);
        step_until_done(-1, 1000, 1'b0, 32'd0, 32'd0, cyc);
        finish_op("lat_pre_flush", cyc);
        issue(32'd3, 32'd3, 1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
        end
        chk("busy_before_flush", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_idle", 64'(bus.busy), 64'd0);
        chk("flush_hi",   64'(bus.hi),   64'h1111_1111);
        chk("flush_lo",   64'(bus.lo),   64'h2222_2222);
        chk("flush_done", 64'(bus.done), 64'd0);
        bus.flush = 1'b0;
        issue(32'd5, 32'd5, 1'b0, 1'b1);
        step_until_done(-1, 1000, 1'b0, 32'd0, 32'd0, cyc);
        finish_op("lat_after_flush", cyc);

        // 2 x 3 held in EX behind a busy 4 x 5, accepted in the done cycle.
        issue(32'd4, 32'd5, 1'b0, 1'b1);
        step_until_done(-1, 1, 1'b1, 32'd2, 32'd3, cyc);
        chk("lat_4x5", 64'(cyc), 64'd34);
        chk("held_stall_release", 64'(bus.stall), 64'd0);
        chk("held_busy_at_done", 64'(bus.busy), 64'd0);
        sb.push_back(model(32'd2, 32'd3, 1'b0));
        n_push++;
        step_until_done(-1, 1000, 1'b0, 32'd0, 32'd0, cyc);
        finish_op("lat_2x3", cyc);

        repeat (3) @(negedge clk);
        chk("done_count", 64'(n_done), 64'(n_push));
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply sequencer with architectural HI/LO registers for the MIPS pipeline EX stage. Accepts `mult`/`multu` from EX, iterates a radix-2 shift-add product over 32 cycles, and commits the 64-bit result to HI/LO. Serves `mfhi`/`mflo` reads and raises a pipeline stall whenever an EX-stage multiply-unit instruction would observe or disturb an in-flight product.

## Interface
Parameters:
- none (fixed 32-bit operands, 64-bit product)

Ports:
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: EX holds `mult`/`multu`; sampled with `op_a`, `op_b`, `is_signed`
- `is_signed` in 1: 1 = `mult`, 0 = `multu`
- `op_a` in 32: multiplicand (rs)
- `op_b` in 32: multiplier (rt)
- `rd_hi` in 1: EX holds `mfhi`
- `rd_lo` in 1: EX holds `mflo`
- `flush` in 1: abort in-flight multiply (branch/exception squash)
- `busy` out 1: FSM not IDLE
- `stall` out 1: freeze IF/ID/EX this cycle
- `done` out 1: one-cycle pulse, HI/LO just committed
- `hi` out 32: HI register
- `lo` out 32: LO register
- `rd_data` out 32: `hi` if `rd_hi`, else `lo` (combinational)

## Operation
- States: IDLE, RUN, FIX.
- IDLE: `start & ~flush` latches operands (after sign handling), clears accumulator, count=0, goes to RUN. `start` with `flush` is dropped.
- RUN: one iteration per cycle: if multiplier LSB set, add multiplicand to upper accumulator half (33-bit add, carry kept), shift accumulator right by 1. After count 31 goes to FIX.
- FIX: apply sign correction (two's-complement negate of 64-bit product when required), write HI/LO, go to IDLE, `done`=1 for the following cycle.
- `flush` in RUN or FIX: IDLE at next edge; HI/LO unchanged; no `done`.
- `busy` = state != IDLE.
- `stall` = `busy & (start | rd_hi | rd_lo)`. A `start` arriving while busy is not queued; the stall holds it in EX until IDLE, then it is accepted.
- `start` with `rd_hi`/`rd_lo` in IDLE cannot occur in one instruction; the read takes no priority over an accept.
- `rd_data` always reflects current HI/LO register contents; no bypass from the accumulator.
- Reset values: state IDLE, `hi`=0, `lo`=0, `done`=0, `busy`=0, `stall`=0, count=0, accumulator=0.
- `rst` mid-operation: same as reset; product discarded.

## Timing
- Edge 0: `start` accepted. Edges 1-32: RUN iterations. Edge 33: FIX commits HI/LO.
- `done`=1 and new `hi`/`lo` visible in cycle after edge 33; `busy`=0 in that cycle.
- Start-to-result latency: 34 cycles; back-to-back issue rate: one multiply per 34 cycles.
- Stalled `mfhi`/`mflo` released in the `done` cycle and reads the new value.
- `flush` takes effect at the next edge; a `start` in the cycle after flush is accepted.

## Configuration
- `MULDIV_SIGNED_EN` defined: `is_signed`=1 converts each operand to 32-bit magnitude at accept (magnitude of 0x80000000 is 2^31, fits unsigned) and negates the product in FIX when the operand signs differ.
- Not defined: `is_signed` ignored; all multiplies unsigned. FIX still occupies one cycle, so latency is identical in both builds.

## Test plan
- Reset: assert `rst` 2 cycles with `start`=1 -> `hi`=`lo`=0, `busy`=`stall`=`done`=0; no multiply starts.
- `multu` 0xFFFFFFFF x 0xFFFFFFFF -> `done` exactly 34 cycles after accept, `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` high exactly one cycle.
- Signed with macro: -3 x 5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; 0x80000000 x 0x80000000 -> `hi`=0x40000000, `lo`=0. Without macro: -3 x 5 -> `hi`=0x00000004, `lo`=0xFFFFFFF1.
- `mflo` presented 10 cycles after accepting 7 x 6 -> `stall`=1 until the `done` cycle, then `stall`=0 and `rd_data`=0x0000002A.
- `flush` 15 cycles into a multiply with prior HI/LO = 0x11111111/0x22222222 -> IDLE next edge, `done` never pulses, HI/LO unchanged; `start` next cycle is accepted.
- Second `start` (2 x 3) held during a busy 4 x 5 -> `stall`=1 until `done` (HI/LO=0/20), accepted that cycle, 34 cycles later HI/LO=0/6.
